// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: FSM states, error codes,
// the default divider latency and the requester-id width helper.
package div_arb_pkg;

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_DBZ   = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    localparam int DIV_CYCLES_DEF = 514;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request strictly after ptr,
// wrapping modulo NREQ, returned both one-hot and as an index.
module rr_picker
    import div_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        // Offsets 1..NREQ so that ptr itself is searched last.
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one non-restoring divider among NREQ requesters: round-robin grant,
// operand screening, start/done sequencing with watchdog, tagged response.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 512,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int TIMEOUT    = DIV_CYCLES + 8,
    localparam int IDW       = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_quot,
    output logic [WIDTH-1:0]      resp_rem,
    output logic [1:0]            resp_err,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_q,
    output logic [WIDTH-1:0]      div_m,
    output logic [WIDTH-1:0]      div_a,
    input  logic                  div_done,
    input  logic [WIDTH-1:0]      div_q_out,
    input  logic [WIDTH-1:0]      div_r
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DIV_CYCLES + 3);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);

    state_t            state, next;
    logic [CW-1:0]     cnt;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    lat_id;
    logic [WIDTH-1:0]  lat_a;
    logic [WIDTH-1:0]  lat_b;
    logic              tmo_flag;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    pick_id;
    logic              pick_any;

    logic              drain_done;
    logic              tmo_hit;
    logic              done_ok;
    logic              div_zero;
    logic              div_big;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (pick_id),
        .any      (pick_any)
    );

    assign drain_done = (cnt == DRAIN_LAST);
    assign tmo_hit    = (cnt == TMO_LAST);
    // cnt is zero only in the first BUSY cycle, where done may still be the
    // sticky flag left over from the previous operation.
    assign done_ok    = div_done && (cnt != '0);
    assign div_zero   = (lat_b == '0);
    assign div_big    = lat_b[WIDTH-1];

    assign div_q = lat_a;
    assign div_m = lat_b;
    assign div_a = '0;

    always_ff @(posedge clk) begin
        if (rst) state <= S_DRAIN;
        else     state <= next;
    end

    always_comb begin
        next       = state;
        req_ready  = '0;
        resp_valid = 1'b0;
        div_start  = 1'b0;
        case (state)
            S_DRAIN: begin
                if (drain_done) next = S_IDLE;
            end
            S_IDLE: begin
                req_ready = grant;
                if (pick_any) next = S_CHECK;
            end
            S_CHECK: begin
                if (div_zero || div_big) next = S_RESP;
                else                     next = S_ISSUE;
            end
            S_ISSUE: begin
                div_start = 1'b1;
                next      = S_BUSY;
            end
            S_BUSY: begin
                if (done_ok || tmo_hit) next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next = tmo_flag ? S_DRAIN : S_IDLE;
            end
            default: next = S_DRAIN;
        endcase
    end

    // One counter serves DRAIN length and BUSY watchdog; it restarts on every
    // state change so each use begins from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (next != state) begin
            cnt <= '0;
        end else if (state == S_DRAIN || state == S_BUSY) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= IDW'(NREQ - 1);
            lat_id    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            tmo_flag  <= 1'b0;
            resp_id   <= '0;
            resp_quot <= '0;
            resp_rem  <= '0;
            resp_err  <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        lat_id <= pick_id;
                        lat_a  <= req_dividend[pick_id*WIDTH +: WIDTH];
                        lat_b  <= req_divisor[pick_id*WIDTH +: WIDTH];
                    end
                end
                S_CHECK: begin
                    resp_id  <= lat_id;
                    tmo_flag <= 1'b0;
                    if (div_zero) begin
                        resp_quot <= '1;
                        resp_rem  <= lat_a;
                        resp_err  <= ERR_DBZ;
                    end else if (div_big) begin
                        resp_quot <= '0;
                        resp_rem  <= '0;
                        resp_err  <= ERR_RANGE;
                    end
                end
                S_BUSY: begin
                    if (done_ok) begin
                        resp_quot <= div_q_out;
                        resp_rem  <= div_r;
                        resp_err  <= ERR_OK;
                    end else if (tmo_hit) begin
                        resp_quot <= '0;
                        resp_rem  <= '0;
                        resp_err  <= ERR_TMO;
                        tmo_flag  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) ptr <= lat_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized scoreboard bench for div_arbiter with a behavioural divider that
// keeps done sticky for a cycle after start and can be made to never finish.
module tb_div_arbiter;
    import div_arb_pkg::*;

    localparam int N         = 4;
    localparam int W         = 512;
    localparam int DC        = 514;
    localparam int TMO       = DC + 8;
    localparam int DRAIN_LEN = DC + 4;
    localparam int IDW       = id_width(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_dividend;
    logic [N*W-1:0]    req_divisor;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_quot;
    logic [W-1:0]      resp_rem;
    logic [1:0]        resp_err;
    logic              div_start;
    logic [W-1:0]      div_q;
    logic [W-1:0]      div_m;
    logic [W-1:0]      div_a;
    logic              div_done  = 1'b1;
    logic [W-1:0]      div_q_out = '1;
    logic [W-1:0]      div_r     = '1;

    div_arbiter #(.NREQ(N), .WIDTH(W), .DIV_CYCLES(DC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_err(resp_err),
        .div_start(div_start), .div_q(div_q), .div_m(div_m), .div_a(div_a),
        .div_done(div_done), .div_q_out(div_q_out), .div_r(div_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural divider: DC cycles from start to done, no reset.
    logic [W-1:0] mq, mm;
    int   mcnt  = 0;
    logic mbusy = 1'b0;
    logic mclr  = 1'b0;
    logic stuck;
    always @(posedge clk) begin
        if (div_start) begin
            mq <= div_q; mm <= div_m; mbusy <= 1'b1; mcnt <= 1; mclr <= 1'b1;
        end else begin
            mclr <= 1'b0;
            if (mclr) div_done <= 1'b0;
            if (mbusy) begin
                mcnt <= mcnt + 1;
                if (mcnt == DC - 1) begin
                    mbusy <= 1'b0;
                    if (!stuck) begin
                        div_done  <= 1'b1;
                        div_q_out <= mq / mm;
                        div_r     <= mq % mm;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic [1:0]     err;
        int             due;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    logic [N-1:0] want;
    logic [N-1:0] last_grant = '0;
    logic         rr_rand, rr_val;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    logic         rst_q = 1'b0;
    int           ref_ptr = N - 1;
    int           earliest = 0;
    int           exp_start = -1;
    logic [W-1:0] st_a, st_b;
    logic         seen = 1'b0;
    exp_t         sv, e;
    int           exp_id, idx;

    always @(negedge clk) begin
        if (rst_q) begin
            chk("reset_resp_valid", W'(resp_valid), '0);
            chk("reset_req_ready", W'(req_ready), '0);
            chk("reset_div_start", W'(div_start), '0);
            chk("reset_resp_id", W'(resp_id), '0);
            chk("reset_resp_quot", resp_quot, '0);
            chk("reset_resp_rem", resp_rem, '0);
            chk("reset_resp_err", W'(resp_err), '0);
            chk("reset_div_q", div_q, '0);
            chk("reset_div_m", div_m, '0);
        end
        if (rst) begin
            sbq.delete();
            seen = 1'b0; ref_ptr = N - 1; exp_start = -1; last_grant = '0;
            earliest = cyc + DRAIN_LEN + 1;
        end else begin
            last_grant = req_ready;
            if (req_ready != '0) begin
                exp_id = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (ref_ptr + k) % N;
                    if (exp_id < 0 && req_valid[idx]) exp_id = idx;
                end
                chk("grant_pick", W'(req_ready), (exp_id < 0) ? '0 : (W'(1) << exp_id));
                chk("grant_while_busy", W'(sbq.size()), '0);
                chk("grant_before_drain_end", W'(cyc >= earliest), W'(1));
                if (exp_id >= 0) begin
                    e.id = IDW'(exp_id);
                    if (opb[exp_id] == '0) begin
                        e.q = '1; e.r = opa[exp_id]; e.err = ERR_DBZ; e.due = cyc + 2;
                    end else if (opb[exp_id][W-1]) begin
                        e.q = '0; e.r = '0; e.err = ERR_RANGE; e.due = cyc + 2;
                    end else begin
                        exp_start = cyc + 2; st_a = opa[exp_id]; st_b = opb[exp_id];
                        if (stuck) begin
                            e.q = '0; e.r = '0; e.err = ERR_TMO; e.due = cyc + 3 + TMO;
                        end else begin
                            e.q = opa[exp_id] / opb[exp_id]; e.r = opa[exp_id] % opb[exp_id];
                            e.err = ERR_OK; e.due = cyc + 3 + DC;
                        end
                    end
                    sbq.push_back(e);
                end
            end else if (sbq.size() == 0 && cyc >= earliest && req_valid != '0) begin
                chk("grant_missing", W'(req_ready != '0), W'(1));
            end

            if (div_start) begin
                chk("start_cycle", W'(cyc), W'(exp_start));
                chk("start_dividend", div_q, st_a);
                chk("start_divisor", div_m, st_b);
                exp_start = -1;
            end

            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    chk("resp_spurious", W'(resp_valid), '0);
                end else if (!seen) begin
                    e = sbq[0];
                    chk("resp_id", W'(resp_id), W'(e.id));
                    chk("resp_quot", resp_quot, e.q);
                    chk("resp_rem", resp_rem, e.r);
                    chk("resp_err", W'(resp_err), W'(e.err));
                    chk("resp_latency", W'(cyc), W'(e.due));
                    sv.id = resp_id; sv.q = resp_quot; sv.r = resp_rem; sv.err = resp_err;
                    seen = 1'b1;
                end else begin
                    chk("hold_id", W'(resp_id), W'(sv.id));
                    chk("hold_quot", resp_quot, sv.q);
                    chk("hold_rem", resp_rem, sv.r);
                    chk("hold_err", W'(resp_err), W'(sv.err));
                end
                if (resp_ready && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    ref_ptr  = int'(e.id);
                    earliest = (e.err == ERR_TMO) ? cyc + DRAIN_LEN + 1 : cyc + 1;
                    seen     = 1'b0;
                end
            end
        end
        rst_q = rst;
    end

    // ---------------- stimulus ----------------
    task automatic apply();
        req_valid = want;
        for (int i = 0; i < N; i++) begin
            req_dividend[i*W +: W] = opa[i];
            req_divisor[i*W +: W]  = opb[i];
        end
        resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        want = want & ~last_grant;
        apply();
    endtask

    task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[i] = a; opb[i] = b; want[i] = 1'b1;
        apply();
    endtask

    task automatic rand_wide(output logic [W-1:0] v);
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
    endtask

    // kind: 0 divide-by-zero, 1 out of range, 2 legal, <0 random mix
    task automatic gen(input int kind, output logic [W-1:0] a, output logic [W-1:0] b);
        int k;
        k = kind;
        if (k < 0) k = ($urandom_range(0, 9) < 3) ? 0 : (($urandom_range(0, 9) < 4) ? 1 : 2);
        rand_wide(a);
        rand_wide(b);
        if (k == 0) b = '0;
        else if (k == 1) b[W-1] = 1'b1;
        else begin
            b = b >> $urandom_range(1, W - 1);
            if (b == '0) b = W'(1);
        end
    endtask

    task automatic wait_idle(input int limit, input string nm);
        int n;
        n = 0;
        while (!(want == '0 && sbq.size() == 0 && !resp_valid) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_%s: still busy after %0d cycles, expected idle", nm, limit);
        end
    endtask

    logic [W-1:0] a, b;
    int n;

    initial begin
        rst = 1'b1; want = '0; rr_rand = 1'b0; rr_val = 1'b1; stuck = 1'b0;
        for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
        apply();
        repeat (4) tick();
        rst = 1'b0;

        post(0, W'(100), W'(7));
        wait_idle(DRAIN_LEN + 700, "first");

        post(1, W'(55), '0);
        wait_idle(50, "dbz");

        for (int i = 0; i < N; i++) begin gen(2, a, b); post(i, a, b); end
        wait_idle(N * 600, "all4");
        for (int i = 0; i < N; i++) begin gen(-1, a, b); post(i, a, b); end
        wait_idle(N * 600, "wrap");

        rr_val = 1'b0;
        gen(2, a, b); post(2, a, b);
        n = 0;
        while (!resp_valid && n < 1000) begin tick(); n++; end
        checks++;
        if (n >= 1000) begin errors++; $display("FAIL wait_hold: resp_valid 0 after 1000 cycles, expected 1"); end
        gen(-1, a, b); post(3, a, b);
        repeat (50) tick();
        rr_val = 1'b1;
        wait_idle(1200, "hold");

        stuck = 1'b1;
        gen(2, a, b); post(0, a, b);
        wait_idle(TMO + 50, "tmo");
        stuck = 1'b0;
        gen(2, a, b); post(1, a, b);
        wait_idle(DRAIN_LEN + 600, "post_tmo");

        gen(2, a, b); post(3, a, b);
        n = 0;
        while (want[3] && n < 100) begin tick(); n++; end
        repeat (200) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a = W'(1) << 100;
        post(2, a, W'(3));
        wait_idle(DRAIN_LEN + 600, "post_rst");

        rr_rand = 1'b1;
        repeat (6000) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(0, 63) == 0) begin gen(-1, a, b); post(i, a, b); end
            end
            tick();
        end
        rr_rand = 1'b0; rr_val = 1'b1;
        apply();
        wait_idle(20000, "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
